// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = 2;
    localparam logic [7:0]  CSUM_GOOD      = 8'h00;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB first and flags the
// byte that completes a word.
//   clk, rst_n   clock, async active-low reset
//   clr          discard any partial word (restart)
//   shift        accept in_data this cycle
//   in_data      stream byte
//   word         assembled word (registered)
//   word_full_c  high on the cycle the 4th byte of a word is shifted in
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift,
    input  logic [BYTE_W-1:0] in_data,
    output logic [WORD_W-1:0] word,
    output logic              word_full_c
);

    logic [BYTE_IDX_W-1:0] idx_q;

    assign word_full_c = shift && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    // Shift register and byte index; index wraps naturally after 4 bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word  <= '0;
            idx_q <= '0;
        end else if (clr) begin
            word  <= '0;
            idx_q <= '0;
        end else if (shift) begin
            word  <= {word[WORD_W-BYTE_W-1:0], in_data};
            idx_q <= idx_q + BYTE_IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte stream and
// writes it as big-endian words into instruction memory from address 0,
// holding the core until the image is complete and verified.
//   clk, rst_n  clock, async active-low reset
//   start       restart from the header, discarding any partial frame
//   in_valid/in_ready/in_data  byte stream handshake
//   im_we/im_addr/im_wdata     instruction-memory write port
//   cpu_hold    core held in reset until done
//   done        image loaded and checksum good (sticky)
//   err         oversize length or bad checksum (sticky)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    loader_state_t    state_q, state_n;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_full_c;
    logic [7:0]       sum_q;
    logic [7:0]       sum_final_c;
    logic             accept_c;
    logic             shift_c;
    logic             word_full_c;
    logic [WORD_W-1:0] word;

    assign accept_c    = in_valid && in_ready;
    assign shift_c     = accept_c && !start && (state_q == DATA);
    assign len_full_c  = {len_q[LEN_W-1:BYTE_W], in_data};
    assign sum_final_c = sum_q + in_data;

    byte_word_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (start),
        .shift       (shift_c),
        .in_data     (in_data),
        .word        (word),
        .word_full_c (word_full_c)
    );

    assign im_wdata = word;
    assign im_addr  = ADDR_W'({cnt_q, 2'b00});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LEN_HI;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic; start overrides everything, including a byte in flight.
    always_comb begin
        state_n = state_q;
        if (start) begin
            state_n = LEN_HI;
        end else begin
            case (state_q)
                LEN_HI: if (accept_c) state_n = LEN_LO;
                LEN_LO: begin
                    if (accept_c) begin
                        if (len_full_c > LEN_W'(DEPTH_WORDS)) begin
                            state_n = ERR;
                        end else if (len_full_c == '0) begin
                            state_n = CSUM;
                        end else begin
                            state_n = DATA;
                        end
                    end
                end
                DATA:   if (word_full_c) state_n = WRITE;
                WRITE:  state_n = ((cnt_q + LEN_W'(1)) == len_q) ? CSUM : DATA;
                CSUM: begin
                    if (accept_c) begin
                        state_n = (sum_final_c == CSUM_GOOD) ? DONE : ERR;
                    end
                end
                DONE:   state_n = DONE;
                ERR:    state_n = ERR;
                default: state_n = LEN_HI;
            endcase
        end
    end

    // Length, word counter and running checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            cnt_q <= '0;
            sum_q <= '0;
        end else if (start) begin
            len_q <= '0;
            cnt_q <= '0;
            sum_q <= '0;
        end else begin
            if (accept_c) begin
                sum_q <= sum_final_c;
            end
            if (accept_c && (state_q == LEN_HI)) begin
                len_q[LEN_W-1:BYTE_W] <= in_data;
            end
            if (accept_c && (state_q == LEN_LO)) begin
                len_q[BYTE_W-1:0] <= in_data;
            end
            if (state_q == WRITE) begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
        end
    end

    // Registered status outputs, decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b1;
            im_we    <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            in_ready <= (state_n == LEN_HI) || (state_n == LEN_LO) ||
                        (state_n == DATA)   || (state_n == CSUM);
            im_we    <= (state_n == WRITE);
            cpu_hold <= (state_n != DONE);
            done     <= (state_n == DONE);
            err      <= (state_n == ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus random frames
// checked against a frame-level model (expected writes = word list at i*4,
// expected status from the byte sum of the frame).
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned DEPTH_WORDS = 256;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int tests = 0;
    int fails = 0;
    int ready_low = 0;
    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Write monitor: record every memory write; no byte may be accepted then.
    always @(negedge clk) begin
        if (rst_n) begin
            if (im_we) begin
                got_addr.push_back(im_addr);
                got_data.push_back(im_wdata);
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL we_ready: in_ready=%b during write, want 0", in_ready);
                end
            end
            if (!in_ready && cpu_hold && !err) ready_low++;
        end
    end

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
        ready_low = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after `gap` idle cycles; returns at the negedge after transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %h not accepted, in_ready=%b", b, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Frame model: header, big-endian words, then byte that makes the sum 0 (or not).
    task automatic make_frame(input logic [31:0] w[$], input bit bad, output logic [7:0] f[$]);
        logic [7:0] s;
        logic [7:0] c;
        logic [15:0] n;
        f = {};
        n = 16'(w.size());
        f.push_back(n[15:8]);
        f.push_back(n[7:0]);
        foreach (w[i]) begin
            f.push_back(w[i][31:24]);
            f.push_back(w[i][23:16]);
            f.push_back(w[i][15:8]);
            f.push_back(w[i][7:0]);
        end
        s = 8'h00;
        foreach (f[i]) s = 8'(s + f[i]);
        c = 8'(8'h00 - s);
        if (bad) c = 8'(c + 8'h01);
        f.push_back(c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        tests++; if (im_we !== 1'b0) begin fails++; $display("FAIL rst_im_we: got %b want 0", im_we); end
        tests++; if (im_addr !== '0) begin fails++; $display("FAIL rst_im_addr: got %h want 0", im_addr); end
        tests++; if (im_wdata !== 32'h0) begin fails++; $display("FAIL rst_im_wdata: got %h want 0", im_wdata); end
        tests++; if (cpu_hold !== 1'b1) begin fails++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", done); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err); end
    endtask

    task automatic test_single_word();
        logic [7:0] f[$];
        f = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'hD2};
        clear_log();
        for (int i = 0; i < 6; i++) send_byte(f[i], 0);
        tests++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL single_pre_csum: hold=%b done=%b want 1/0", cpu_hold, done); end
        send_byte(f[6], 0);
        tests++; if (got_addr.size() != 1) begin fails++; $display("FAIL single_count: got %0d writes want 1", got_addr.size()); end
        else begin
            tests++; if (got_addr[0] !== 10'h000) begin fails++; $display("FAIL single_addr: got %h want 000", got_addr[0]); end
            tests++; if (got_data[0] !== 32'h20080005) begin fails++; $display("FAIL single_data: got %h want 20080005", got_data[0]); end
        end
        tests++; if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL single_status: done=%b hold=%b err=%b want 1/0/0", done, cpu_hold, err);
        end
    endtask

    task automatic test_three_words_toggle();
        logic [31:0] w[$];
        logic [7:0]  f[$];
        pulse_start();
        clear_log();
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        make_frame(w, 1'b0, f);
        foreach (f[i]) send_byte(f[i], 1);
        tests++; if (got_addr.size() != 3) begin fails++; $display("FAIL three_count: got %0d want 3", got_addr.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (got_addr[i] !== ADDR_W'(i * 4) || got_data[i] !== w[i]) begin
                    fails++;
                    $display("FAIL three_write%0d: got %h/%h want %h/%h", i, got_addr[i], got_data[i], ADDR_W'(i * 4), w[i]);
                end
            end
        end
        tests++; if (ready_low != 3) begin fails++; $display("FAIL three_ready_low: got %0d cycles want 3", ready_low); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL three_done: got %b want 1", done); end
    endtask

    task automatic test_bad_csum();
        logic [7:0] f[$];
        f = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'hD3};
        pulse_start();
        clear_log();
        foreach (f[i]) send_byte(f[i], 0);
        tests++; if (got_addr.size() != 1) begin fails++; $display("FAIL badcs_count: got %0d want 1", got_addr.size()); end
        tests++; if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
            fails++; $display("FAIL badcs_status: err=%b done=%b hold=%b rdy=%b want 1/0/1/0", err, done, cpu_hold, in_ready);
        end
    endtask

    task automatic test_oversize();
        pulse_start();
        clear_log();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL over_err: got %b want 1", err); end
        in_valid = 1'b1;
        in_data  = 8'h00;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        tests++; if (in_ready !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL over_sticky: rdy=%b err=%b want 0/1", in_ready, err); end
        tests++; if (got_addr.size() != 0) begin fails++; $display("FAIL over_writes: got %0d want 0", got_addr.size()); end
    endtask

    task automatic test_zero_len();
        pulse_start();
        clear_log();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tests++; if (done !== 1'b1 || got_addr.size() != 0) begin fails++; $display("FAIL zero_done: done=%b writes=%0d want 1/0", done, got_addr.size()); end
        pulse_start();
        tests++; if (cpu_hold !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL zero_restart: hold=%b done=%b rdy=%b want 1/0/1", cpu_hold, done, in_ready);
        end
    endtask

    task automatic test_abort();
        logic [31:0] w[$];
        logic [7:0]  f[$];
        pulse_start();
        clear_log();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        // start together with a valid byte: that byte must be dropped
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        w.push_back(32'hDEADBEEF);
        make_frame(w, 1'b0, f);
        foreach (f[i]) send_byte(f[i], 0);
        tests++; if (got_addr.size() != 1) begin fails++; $display("FAIL abort_count: got %0d want 1", got_addr.size()); end
        else begin
            tests++; if (got_addr[0] !== 10'h000 || got_data[0] !== 32'hDEADBEEF) begin
                fails++; $display("FAIL abort_write: got %h/%h want 000/deadbeef", got_addr[0], got_data[0]);
            end
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL abort_done: got %b want 1", done); end
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 8; k++) begin
            logic [31:0] w[$];
            logic [7:0]  f[$];
            bit          bad;
            int          n;
            pulse_start();
            clear_log();
            n   = $urandom_range(0, 5);
            bad = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) w.push_back($urandom);
            make_frame(w, bad, f);
            foreach (f[i]) send_byte(f[i], $urandom_range(0, 2));
            tests++;
            if (got_addr.size() != n) begin
                fails++; $display("FAIL rnd%0d_count: got %0d want %0d", k, got_addr.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    tests++;
                    if (got_addr[i] !== ADDR_W'(i * 4) || got_data[i] !== w[i]) begin
                        fails++;
                        $display("FAIL rnd%0d_write%0d: got %h/%h want %h/%h", k, i, got_addr[i], got_data[i], ADDR_W'(i * 4), w[i]);
                    end
                end
            end
            tests++;
            if (done !== !bad || err !== bad || cpu_hold !== bad) begin
                fails++; $display("FAIL rnd%0d_status: done=%b err=%b hold=%b bad=%0d", k, done, err, cpu_hold, bad);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] w[$];
        logic [7:0]  f[$];
        pulse_start();
        clear_log();
        w.push_back(32'hCAFEF00D);
        w.push_back(32'h12345678);
        make_frame(w, 1'b0, f);
        for (int i = 0; i < 10; i++) send_byte(f[i], 0);
        tests++; if (im_we !== 1'b1 || im_addr !== 10'h004) begin fails++; $display("FAIL mrst_pre: we=%b addr=%h want 1/004", im_we, im_addr); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1 || im_we !== 1'b0 || im_addr !== '0 || im_wdata !== 32'h0 ||
                     cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL mrst_outputs: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b",
                              in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_three_words_toggle();
        test_bad_csum();
        test_oversize();
        test_zero_len();
        test_abort();
        test_random_frames();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the MIPS core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words, then writes them into instruction memory starting at byte address 0. The core's PC and execution are frozen until the image is fully written and its checksum verifies. In hardware it takes over the instruction-image load that simulation performs with `$readmemb`; it sits between the host link (UART receiver or debug port) and the instruction-memory write port.

## Interface
- `ADDR_W`, 10: instruction-memory byte-address width.
- `DEPTH_WORDS`, 256: instruction-memory capacity in 32-bit words.

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse that aborts any load and restarts from the header
- `in_valid`  in  1  stream byte valid
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader accepts the byte this cycle
- `im_we`  out  1  instruction-memory write strobe, one cycle per word
- `im_addr`  out  ADDR_W  word-aligned byte address; bits [1:0] always 0
- `im_wdata`  out  32  assembled word
- `cpu_hold`  out  1  holds the core in reset with PC = 0
- `done`  out  1  image loaded and checksum good
- `err`  out  1  oversize count or checksum mismatch

## Operation
- Frame format: `LEN_HI`, `LEN_LO` (16-bit word count N, big-endian), then 4·N data bytes (MSB of each word first), then 1 checksum byte. The 8-bit sum of all bytes, including header and checksum, must equal 0x00.
- States and transitions:
  - `LEN_HI` → `LEN_LO` → (`DATA`, or `CSUM` if N = 0).
  - `DATA`: after 4 bytes → `WRITE`.
  - `WRITE`: one cycle; → `DATA` if words remain, else → `CSUM`.
  - `CSUM` → `DONE` if the sum is 0, else → `ERR`.
- A byte transfers on a cycle with `in_valid` and `in_ready` both high. `in_ready` = 1 in `LEN_HI`, `LEN_LO`, `DATA` and `CSUM`; it is 0 in `WRITE`, `DONE` and `ERR`.
- Oversize: N > `DEPTH_WORDS` → `ERR` directly after `LEN_LO`. No memory writes occur and no further bytes are accepted.
- Address and checksum arithmetic:
  - The word counter runs from 0 to N−1.
  - `im_addr` = counter << 2, truncated to `ADDR_W`.
  - The checksum is a running 8-bit modulo-256 add.
- `cpu_hold` = 1 in every state except `DONE`. `done` = 1 only in `DONE`. `err` = 1 only in `ERR`.
- `DONE` and `ERR` are sticky until `start` or reset.
- `start` takes effect from any state, including mid-word: next state is `LEN_HI`, counters and checksum are cleared, and a partial word is discarded. `start` has priority over a simultaneous byte transfer, and that byte is dropped.
- Already-written memory words are not erased on restart.

## Timing
- Reset values: state `LEN_HI`, `in_ready` = 1, `im_we` = 0, `im_addr` = 0, `im_wdata` = 0, `cpu_hold` = 1, `done` = 0, `err` = 0.
- `im_we` pulses in the cycle after the 4th byte of a word is accepted. `im_addr` and `im_wdata` are stable during that cycle.
- Throughput: 5 cycles per word at full rate (4 bytes plus 1 `WRITE` cycle).
- `done` rises, and `cpu_hold` falls, in the cycle after the checksum byte is accepted. The core fetches from PC = 0 on the following edge.
- Reset asserted mid-load returns all outputs to their reset values immediately. Memory contents are undefined for that load.
- Stalls: `in_valid` low in any accepting state holds the state unchanged, with no timeout.

## Structure
- Shared package `imem_loader_pkg` holds:
  - state enum `loader_state_t` (`LEN_HI`, `LEN_LO`, `DATA`, `WRITE`, `CSUM`, `DONE`, `ERR`);
  - the constants `BYTES_PER_WORD` = 4 and `CSUM_GOOD` = 8'h00.
- One natural sub-module, `byte_word_packer`: a 4-byte big-endian shift register with a byte-index counter and a `word_full` flag, cleared by `start`.
- FSM, counters and checksum live in `imem_loader`.

## Test plan
- Single word: stream 00 01 20 08 00 05 D2 → one `im_we` with addr 0x000 and data 0x20080005, then `done` = 1, `cpu_hold` = 0, `err` = 0.
- Three words, with `in_valid` toggling every other cycle: → writes at 0x000, 0x004 and 0x008 with correct data, then `done`. `in_ready` = 0 exactly in each `WRITE` cycle.
- Bad checksum: same as the first scenario but with a final byte of D3 → the write still occurs, then `err` = 1, `done` = 0, `cpu_hold` = 1, `in_ready` = 0.
- Oversize: header 01 01 (N = 257, with `DEPTH_WORDS` = 256) → `err` in the cycle after `LEN_LO`, with no `im_we` ever asserted.
- N = 0: stream 00 00 00 → `done` with no writes. Then a `start` pulse → back to `LEN_HI` with `cpu_hold` = 1.
- Abort: `start` after 2 data bytes, then a full valid frame for word 0xDEADBEEF → a single write of 0xDEADBEEF at 0x000, and the aborted partial bytes never appear. Separately, asserting `rst_n` = 0 mid-frame → all outputs immediately take their reset values.
